tag_lookup_ctrl: RTL
====================

# tag_lookup_ctrl

Lookup and allocation controller that drives the 4-way, 256-set, 18-bit tag block RAM from the cache side. It accepts one address request at a time and issues the indexed read. It compares the four returned tags against the request using the valid bits it owns, and reports hit/way. On an allocating miss it picks a victim (first invalid way, else tree-PLRU) and writes the new tag back with a single-tag write.

## Interface
Parameters: none. Fixed geometry: 32-bit address; tag = addr[31:14], index = addr[13:6], offset = addr[5:0].

- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  controller can accept a request (IDLE and !inv_valid)
- req_addr  in  32  request address
- req_alloc  in  1  allocate on miss
- inv_valid  in  1  invalidate one entry (IDLE only)
- inv_index  in  8  set to invalidate
- inv_way  in  2  way to invalidate
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  request hit
- resp_way  out  2  hit way, or filled way on allocating miss
- resp_evict_valid  out  1  valid tag was replaced
- resp_evict_tag  out  18  replaced tag
- tr_r_index  out  8  tag RAM read set
- tr_tag_out  in  72  tag RAM read data; way w in bits [18w+17:18w]; valid 1 cycle after tr_r_index
- tr_w_index  out  10  tag RAM write address {set, way}
- tr_tag_in  out  18  tag RAM write data
- tr_wr_en  out  1  tag RAM write strobe, one cycle per write

## Operation
- State owned here:
  - valid[256][4]
  - plru[256][3]
  - latched tag_q and idx_q
  - latched alloc_q
- States: IDLE, RD, CMP, WR, RESP.
  - IDLE: req_ready=1 unless inv_valid.
    - inv_valid has priority: clears valid[inv_index][inv_way] that cycle and stays in IDLE. No RAM access and no PLRU change.
    - Otherwise req_valid latches address and alloc, then goes to RD.
  - RD: tr_r_index = idx_q; go to CMP.
  - CMP: hit_w = valid[idx_q][w] && tr_tag_out way w == tag_q; lowest matching way wins.
    - Hit: record way, update PLRU, go to RESP.
    - Miss with alloc_q: choose victim, capture evict tag (old RAM tag of the victim when the victim is valid), go to WR.
    - Miss without alloc: go to RESP with resp_hit=0.
  - WR: tr_wr_en=1, tr_w_index={idx_q,victim}, tr_tag_in=tag_q; set valid, update PLRU; go to RESP.
  - RESP: resp_valid=1 with registered resp_* fields; go to IDLE.
- Victim selection: lowest-numbered invalid way; if all four are valid, use PLRU.
  - p0=0 selects {0,1}, p0=1 selects {2,3}.
  - p1=0 selects way0, p1=1 selects way1.
  - p2=0 selects way2, p2=1 selects way3.
- PLRU update on access to way w (hit or fill):
  - w∈{0,1}: p0=1 and p1=~w[0].
  - w∈{2,3}: p0=0 and p2=~w[0].
- resp_evict_valid=1 only on an allocating miss whose victim was valid. resp_way is 0 on a non-allocating miss.

## Timing
- Reset values:
  - State IDLE; all valid and plru bits 0.
  - req_ready=1.
  - resp_valid=0, resp_hit=0, resp_way=0, resp_evict_valid=0, resp_evict_tag=0.
  - tr_wr_en=0, tr_r_index=0, tr_w_index=0, tr_tag_in=0.
- Latency from the handshake cycle T:
  - Hit or non-allocating miss: resp_valid at T+3.
  - Allocating miss: tr_wr_en at T+3, resp_valid at T+4.
  - Next request can be accepted at T+4 (hit or non-allocating miss) or T+5 (allocating miss).
- req_ready is 0 in all non-IDLE states and does not depend on req_valid.
- tr_wr_en is high only in WR, exactly one cycle per allocation. The tag RAM is never read and written in the same cycle.
- rst in any state (including WR) forces IDLE next cycle.
  - Pending writes and responses are dropped.
  - tr_wr_en and resp_valid are 0 from the cycle after rst is sampled.
- resp_* outputs hold their value outside the resp_valid pulse. The bench samples them only when resp_valid=1.

## Test plan
The bench models the tag RAM with 1-cycle registered read latency.

- Cold allocating miss, addr 0x0001_2340 (tag 0x00004, idx 0x8D), alloc=1:
  - tr_wr_en at T+3 with tr_w_index=0x234 and tr_tag_in=0x00004.
  - resp_valid at T+4: hit=0, way=0, evict_valid=0.
- Repeat of the same addr: resp at T+3 with hit=1, way=0, and no tr_wr_en.
- Fill idx 0x8D with addrs 0x00012340, 0x00016340, 0x0001A340, 0x0001E340 (alloc):
  - Fills ways 0..3 in order.
  - Then 0x00022340 (alloc) evicts way0: evict_valid=1, evict_tag=0x00004, tr_w_index=0x234, tr_tag_in=0x00008.
- Non-allocating miss on addr 0x0000_0040: resp at T+3 with hit=0, way=0, and no write.
- inv_valid for idx 0x8D, way 2, asserted together with req_valid:
  - req_ready=0 that cycle.
  - A lookup of 0x0001A340 then misses; with alloc=1 it fills way2 and evict_valid=0.
- rst asserted in the WR cycle: no tr_wr_en pulse, no resp_valid, req_ready=1 the next cycle, and a following lookup of any prior address misses.

Source files
------------

// File: rtl/tag_lookup_if.sv
// Cache-side request/response and tag-RAM port bundle for tag_lookup_ctrl.
// master: requester plus tag RAM; slave: the lookup controller.
interface tag_lookup_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_alloc;
    logic        inv_valid;
    logic [7:0]  inv_index;
    logic [1:0]  inv_way;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        resp_evict_valid;
    logic [17:0] resp_evict_tag;
    logic [7:0]  tr_r_index;
    logic [71:0] tr_tag_out;
    logic [9:0]  tr_w_index;
    logic [17:0] tr_tag_in;
    logic        tr_wr_en;

    modport master (
        output req_valid, req_addr, req_alloc, inv_valid, inv_index, inv_way, tr_tag_out,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag,
               tr_r_index, tr_w_index, tr_tag_in, tr_wr_en
    );

    modport slave (
        input  req_valid, req_addr, req_alloc, inv_valid, inv_index, inv_way, tr_tag_out,
        output req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag,
               tr_r_index, tr_w_index, tr_tag_in, tr_wr_en
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// 4-way x 256-set tag lookup/allocation controller: indexed read, tag compare,
// first-invalid-else-tree-PLRU victim choice and single-tag write-back.
module tag_lookup_ctrl (
    input  logic         clk,
    input  logic         rst,
    tag_lookup_if.slave  bus
);
    localparam int unsigned TAG_W  = 18;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 256;
    localparam int unsigned PLRU_W = 3;

    typedef enum logic [2:0] {IDLE, RD, CMP, WR, RESP} state_t;

    state_t state;
    state_t next_state;

    // valid bit of {set, way} lives at bit {set, way}; plru bits {p2,p1,p0} per set
    logic [SETS*WAYS-1:0]   valid_bits;
    logic [SETS*PLRU_W-1:0] plru_bits;

    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic             alloc_q;
    logic [1:0]       way_q;
    logic             evv_q;
    logic [TAG_W-1:0] evt_q;
    logic             wr_q;

    logic [WAYS-1:0]   set_valid;
    logic [PLRU_W-1:0] set_plru;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any;
    logic [1:0]        hit_way;
    logic [1:0]        victim;
    logic [TAG_W-1:0]  victim_tag;
    logic              addr_offset_unused;

    assign addr_offset_unused = ^bus.req_addr[5:0];

    function automatic logic [PLRU_W-1:0] plru_next(input logic [PLRU_W-1:0] p,
                                                    input logic [1:0] w);
        logic [PLRU_W-1:0] n;
        n = p;
        if (!w[1]) begin
            n[0] = 1'b1;
            n[1] = ~w[0];
        end else begin
            n[0] = 1'b0;
            n[2] = ~w[0];
        end
        return n;
    endfunction

    // Tag compare and victim choice for the set being looked up
    always_comb begin
        set_valid = valid_bits[{idx_q, 2'b00} +: WAYS];
        set_plru  = plru_bits[PLRU_W*idx_q +: PLRU_W];
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = set_valid[w] && (bus.tr_tag_out[TAG_W*w +: TAG_W] == tag_q);
        end
        hit_any = |hit_vec;
        if (hit_vec[0])      hit_way = 2'd0;
        else if (hit_vec[1]) hit_way = 2'd1;
        else if (hit_vec[2]) hit_way = 2'd2;
        else                 hit_way = 2'd3;
        if (!set_valid[0])      victim = 2'd0;
        else if (!set_valid[1]) victim = 2'd1;
        else if (!set_valid[2]) victim = 2'd2;
        else if (!set_valid[3]) victim = 2'd3;
        else if (!set_plru[0])  victim = {1'b0, set_plru[1]};
        else                    victim = {1'b1, set_plru[2]};
        victim_tag = bus.tr_tag_out[TAG_W*victim +: TAG_W];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !bus.inv_valid;
                if (!bus.inv_valid && bus.req_valid) next_state = RD;
            end
            RD:   next_state = CMP;
            CMP: begin
                if (hit_any)      next_state = RESP;
                else if (alloc_q) next_state = WR;
                else              next_state = RESP;
            end
            WR:   next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A reset landing in the WR cycle must not let the strobe reach the RAM
    assign bus.tr_wr_en = wr_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits           <= '0;
            plru_bits            <= '0;
            tag_q                <= '0;
            idx_q                <= '0;
            alloc_q              <= 1'b0;
            way_q                <= 2'd0;
            evv_q                <= 1'b0;
            evt_q                <= '0;
            wr_q                 <= 1'b0;
            bus.resp_valid       <= 1'b0;
            bus.resp_hit         <= 1'b0;
            bus.resp_way         <= 2'd0;
            bus.resp_evict_valid <= 1'b0;
            bus.resp_evict_tag   <= '0;
            bus.tr_r_index       <= '0;
            bus.tr_w_index       <= '0;
            bus.tr_tag_in        <= '0;
        end else begin
            wr_q           <= (next_state == WR);
            bus.resp_valid <= (next_state == RESP);
            case (state)
                IDLE: begin
                    if (bus.inv_valid) begin
                        valid_bits[{bus.inv_index, bus.inv_way}] <= 1'b0;
                    end else if (bus.req_valid) begin
                        tag_q          <= bus.req_addr[31:14];
                        idx_q          <= bus.req_addr[13:6];
                        alloc_q        <= bus.req_alloc;
                        bus.tr_r_index <= bus.req_addr[13:6];
                    end
                end
                CMP: begin
                    if (hit_any) begin
                        bus.resp_hit         <= 1'b1;
                        bus.resp_way         <= hit_way;
                        bus.resp_evict_valid <= 1'b0;
                        bus.resp_evict_tag   <= '0;
                        plru_bits[PLRU_W*idx_q +: PLRU_W] <= plru_next(set_plru, hit_way);
                    end else if (alloc_q) begin
                        way_q          <= victim;
                        evv_q          <= set_valid[victim];
                        evt_q          <= set_valid[victim] ? victim_tag : '0;
                        bus.tr_w_index <= {idx_q, victim};
                        bus.tr_tag_in  <= tag_q;
                    end else begin
                        bus.resp_hit         <= 1'b0;
                        bus.resp_way         <= 2'd0;
                        bus.resp_evict_valid <= 1'b0;
                        bus.resp_evict_tag   <= '0;
                    end
                end
                WR: begin
                    valid_bits[{idx_q, way_q}]        <= 1'b1;
                    plru_bits[PLRU_W*idx_q +: PLRU_W] <= plru_next(set_plru, way_q);
                    bus.resp_hit         <= 1'b0;
                    bus.resp_way         <= way_q;
                    bus.resp_evict_valid <= evv_q;
                    bus.resp_evict_tag   <= evt_q;
                end
                default: ;
            endcase
        end
    end
endmodule
